hsi_link_supervisor: RTL and testbench
======================================

Name: hsi_link_supervisor

Overview:
Parametrised reply supervisor for the HSI master link, the successor to the fixed 3-source emergency controller. It watches each issued command for a reply, using a per-command reply window and a frame-length watchdog. On a missing or bad reply it issues per-source repeat requests, rotates through N redundant com/dat line pairs after a set number of retries, and declares a sticky link failure once every line is exhausted. It sits between the master TX controller (cmd_sent) and RX controller (start/end/err) and drives the line-select for the com/dat muxes.

Parameters:
N_SRC, 3, number of command sources (bit 0 = SR, bit 1 = DPR, bit 2 = CCW by convention)
N_LINES, 2, number of redundant line pairs; must be >= 1
TO_W, 16, width of the reply-window count
FRAME_TO, 4096, maximum cycles from accepted start bit to frame end
MAX_RETRY, 2, repeats on the same line before rotating; must be >= 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_sent  in  1  one-cycle pulse: command frame transmitted
cmd_src  in  clog2(N_SRC)  source index of cmd_sent
reply_delay  in  TO_W  reply window in cycles, sampled with cmd_sent; 0 = no reply expected
rx_start_bit  in  1  pulse: reply start bit accepted
rx_frame_end  in  1  pulse: reply frame finished
rx_err  in  1  qualifies rx_frame_end: frame erroneous
fail_clr  in  1  pulse: clear link_fail, return to IDLE
repeat_req  out  N_SRC  one-hot one-cycle pulse: repeat the command of that source
line_sel  out  clog2(N_LINES) (min 1)  active line pair index
line_toggle  out  1  one-cycle pulse when line_sel changes
link_fail  out  1  sticky: all lines exhausted
busy  out  1  high in WAIT_START/WAIT_END
cmd_drop  out  1  one-cycle pulse: cmd_sent ignored (not IDLE or cmd_src >= N_SRC)

Behaviour:
- Reset: state IDLE, all outputs 0, line_sel 0, internal retry and line-tried counters 0, timers 0.
- All outputs are registered.
- IDLE:
  - cmd_sent with valid cmd_src and reply_delay > 0: latch src, timer <= reply_delay, go to WAIT_START.
  - cmd_sent with reply_delay == 0: counts as success; clear retry and line-tried counters; stay IDLE.
  - rx_* inputs are ignored in IDLE.
- WAIT_START:
  - timer decrements every cycle.
  - rx_start_bit: go to WAIT_END, frame timer <= FRAME_TO.
  - rx_frame_end without a prior start: failure.
  - Timer == 1 with no rx_start_bit: failure (timeout).
  - rx_start_bit coincident with expiry: start wins.
- WAIT_END:
  - rx_frame_end & ~rx_err: success. Clear retry and line-tried counters, go to IDLE. line_sel is kept.
  - rx_frame_end & rx_err: failure.
  - Frame timer reaching 1 with no rx_frame_end: failure.
- Failure (one-cycle evaluation, then IDLE):
  - If retry < MAX_RETRY: retry++, pulse repeat_req[src].
  - Else if line_tried < N_LINES-1: retry <= 0, line_tried++, line_sel <= (line_sel+1) mod N_LINES (wraps from N_LINES-1 to 0), pulse line_toggle and repeat_req[src] in the same cycle.
  - Else: go to FAIL, link_fail <= 1, no repeat_req.
- FAIL:
  - Every cmd_sent gives cmd_drop.
  - fail_clr: link_fail <= 0, counters <= 0, line_sel kept, go to IDLE.
- Latency: cmd_sent in cycle c0 with reply_delay = D and no reply gives the response in cycle c0+D+1. rx_start_bit is honoured in cycles c1..cD.
- cmd_sent while busy: cmd_drop pulse; the supervised command is unaffected.
- rst mid-operation: immediate return to reset values; pending repeat is discarded.
- N_LINES == 1: line_toggle never asserts; failure after MAX_RETRY repeats goes straight to FAIL.

Test Plan:
- Defaults. cmd_sent, src 1, D=10; no reply -> repeat_req = 3'b010 exactly in cycle c11; busy high c1..c11, low at c12.
- D=10; rx_start_bit in c10 (expiry cycle); rx_frame_end, rx_err=0 after 20 cycles -> no repeat_req; busy drops the cycle after frame_end; retry counter cleared.
- src 2, three consecutive timeouts (MAX_RETRY=2) -> repeat_req = 3'b100 three times. The third also pulses line_toggle with line_sel 0->1.
- Three more timeouts on line 1 -> line 1 exhausted (N_LINES=2, no wrap) -> link_fail = 1, no repeat_req. Further cmd_sent gives cmd_drop. fail_clr -> link_fail 0, line_sel stays 1.
- Start bit, then no frame_end for FRAME_TO=4096 cycles -> repeat_req asserts 4096 cycles after the start-bit cycle. rx_frame_end with rx_err=1 -> repeat_req.
- Assert rst while in WAIT_END -> all outputs 0, line_sel 0 next cycle. cmd_src=3 with N_SRC=3 -> cmd_drop, state stays IDLE.

Source files
------------

// File: rtl/hsi_link_supervisor.sv
// Reply supervisor for the HSI master link: times each command's reply, requests
// repeats, rotates through redundant line pairs and latches a sticky link failure.
module hsi_link_supervisor #(
  parameter int N_SRC     = 3,
  parameter int N_LINES   = 2,
  parameter int TO_W      = 16,
  parameter int FRAME_TO  = 4096,
  parameter int MAX_RETRY = 2,
  localparam int SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int LINE_W   = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_sent,
  input  logic [SRC_W-1:0]  cmd_src,
  input  logic [TO_W-1:0]   reply_delay,
  input  logic              rx_start_bit,
  input  logic              rx_frame_end,
  input  logic              rx_err,
  input  logic              fail_clr,
  output logic [N_SRC-1:0]  repeat_req,
  output logic [LINE_W-1:0] line_sel,
  output logic              line_toggle,
  output logic              link_fail,
  output logic              busy,
  output logic              cmd_drop
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FT_W    = $clog2(FRAME_TO + 1);
  localparam int TMR_W   = (TO_W > FT_W) ? TO_W : FT_W;

  localparam logic [SRC_W:0]       SRC_LIM   = (SRC_W + 1)'(N_SRC);
  localparam logic [RETRY_W-1:0]   RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [LINE_W-1:0]    LINE_LAST = LINE_W'(N_LINES - 1);
  // The start-bit cycle itself counts as the first cycle of the frame window.
  localparam logic [TMR_W-1:0]     FRAME_LOAD = TMR_W'((FRAME_TO > 1) ? FRAME_TO - 1 : 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_WAIT_END   = 3'd2,
    S_EVAL       = 3'd3,
    S_FAIL       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LINE_W-1:0]  tried_q, tried_d;
  logic [LINE_W-1:0]  line_sel_q, line_sel_d;
  logic [N_SRC-1:0]   repeat_req_q, repeat_req_d;
  logic               line_toggle_q, line_toggle_d;
  logic               link_fail_q, link_fail_d;
  logic               busy_q, busy_d;
  logic               cmd_drop_q, cmd_drop_d;
  logic               src_ok;
  logic               fail_now;

  assign src_ok = ({1'b0, cmd_src} < SRC_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      src_q         <= '0;
      retry_q       <= '0;
      tried_q       <= '0;
      line_sel_q    <= '0;
      repeat_req_q  <= '0;
      line_toggle_q <= 1'b0;
      link_fail_q   <= 1'b0;
      busy_q        <= 1'b0;
      cmd_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      src_q         <= src_d;
      retry_q       <= retry_d;
      tried_q       <= tried_d;
      line_sel_q    <= line_sel_d;
      repeat_req_q  <= repeat_req_d;
      line_toggle_q <= line_toggle_d;
      link_fail_q   <= link_fail_d;
      busy_q        <= busy_d;
      cmd_drop_q    <= cmd_drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    src_d         = src_q;
    retry_d       = retry_q;
    tried_d       = tried_q;
    line_sel_d    = line_sel_q;
    link_fail_d   = link_fail_q;
    repeat_req_d  = '0;
    line_toggle_d = 1'b0;
    cmd_drop_d    = 1'b0;
    fail_now      = 1'b0;

    if (cmd_sent && !((state_q == S_IDLE) && src_ok)) begin
      cmd_drop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_sent && src_ok) begin
          if (reply_delay != '0) begin
            src_d   = cmd_src;
            timer_d = TMR_W'(reply_delay);
            state_d = S_WAIT_START;
          end else begin
            // No reply expected: treated as a successful exchange.
            retry_d = '0;
            tried_d = '0;
          end
        end
      end

      S_WAIT_START: begin
        timer_d = timer_q - TMR_W'(1);
        if (rx_start_bit) begin
          timer_d = FRAME_LOAD;
          state_d = S_WAIT_END;
        end else if (rx_frame_end || (timer_q == TMR_W'(1))) begin
          fail_now = 1'b1;
        end
      end

      S_WAIT_END: begin
        timer_d = timer_q - TMR_W'(1);
        if (rx_frame_end) begin
          if (rx_err) begin
            fail_now = 1'b1;
          end else begin
            retry_d = '0;
            tried_d = '0;
            state_d = S_IDLE;
          end
        end else if (timer_q == TMR_W'(1)) begin
          fail_now = 1'b1;
        end
      end

      S_EVAL: begin
        state_d = link_fail_q ? S_FAIL : S_IDLE;
      end

      S_FAIL: begin
        if (fail_clr) begin
          link_fail_d = 1'b0;
          retry_d     = '0;
          tried_d     = '0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Failure outcome is registered on the same edge that leaves the wait state.
    if (fail_now) begin
      state_d = S_EVAL;
      if (retry_q < RETRY_LIM) begin
        retry_d      = retry_q + RETRY_W'(1);
        repeat_req_d = N_SRC'(1) << src_q;
      end else if (tried_q < LINE_LAST) begin
        retry_d       = '0;
        tried_d       = tried_q + LINE_W'(1);
        line_sel_d    = (line_sel_q == LINE_LAST) ? '0 : line_sel_q + LINE_W'(1);
        line_toggle_d = 1'b1;
        repeat_req_d  = N_SRC'(1) << src_q;
      end else begin
        link_fail_d = 1'b1;
      end
    end

    busy_d = (state_d == S_WAIT_START) || (state_d == S_WAIT_END) || (state_d == S_EVAL);
  end

  assign repeat_req  = repeat_req_q;
  assign line_sel    = line_sel_q;
  assign line_toggle = line_toggle_q;
  assign link_fail   = link_fail_q;
  assign busy        = busy_q;
  assign cmd_drop    = cmd_drop_q;

endmodule

// File: tb/tb_hsi_link_supervisor.sv
// Self-checking bench for hsi_link_supervisor: directed scenarios plus randomized
// transactions checked cycle by cycle against a retry/line bookkeeping model.
module tb_hsi_link_supervisor;

  localparam int N_SRC     = 3;
  localparam int N_LINES   = 2;
  localparam int TO_W      = 16;
  localparam int FRAME_TO  = 4096;
  localparam int MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_sent;
  logic [1:0]  cmd_src;
  logic [15:0] reply_delay;
  logic        rx_start_bit;
  logic        rx_frame_end;
  logic        rx_err;
  logic        fail_clr;
  logic [2:0]  repeat_req;
  logic [0:0]  line_sel;
  logic        line_toggle;
  logic        link_fail;
  logic        busy;
  logic        cmd_drop;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Reference bookkeeping: repeats used on the current line, extra lines tried,
  // the active line, and whether the link has been declared dead.
  int m_retry = 0;
  int m_tried = 0;
  int m_line  = 0;
  bit m_fail  = 0;

  hsi_link_supervisor #(
    .N_SRC(N_SRC), .N_LINES(N_LINES), .TO_W(TO_W),
    .FRAME_TO(FRAME_TO), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .cmd_sent(cmd_sent), .cmd_src(cmd_src),
    .reply_delay(reply_delay), .rx_start_bit(rx_start_bit),
    .rx_frame_end(rx_frame_end), .rx_err(rx_err), .fail_clr(fail_clr),
    .repeat_req(repeat_req), .line_sel(line_sel), .line_toggle(line_toggle),
    .link_fail(link_fail), .busy(busy), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One supervised command. start_at/early_end are cycle indices after cmd_sent
  // (0 = none); end_after counts cycles from the start bit (0 = never).
  task automatic run_txn(input int src, input int d, input int start_at, input int end_after,
                         input bit err, input int early_end, input bit extra);
    bit succ;
    int r, e, last_k;
    int n_retry, n_tried, n_line;
    bit n_fail, f_tog, exp_busy, exp_tog, exp_drop;
    logic [2:0] f_rep, exp_rep;
    string outcome;

    r = 0; e = 0; succ = 0;
    if (d == 0) succ = 1;
    else if (early_end > 0) r = early_end + 1;
    else if (start_at == 0) r = d + 1;
    else if (end_after == 0) r = start_at + FRAME_TO;
    else begin
      e = start_at + end_after;
      if (err) r = e + 1;
      else succ = 1;
    end

    n_retry = m_retry; n_tried = m_tried; n_line = m_line; n_fail = m_fail;
    f_rep = '0; f_tog = 0; outcome = "ok";
    if (!succ) begin
      if (m_retry < MAX_RETRY) begin
        n_retry = m_retry + 1; f_rep = 3'(1 << src); outcome = "repeat";
      end else if (m_tried < N_LINES - 1) begin
        n_retry = 0; n_tried = m_tried + 1; n_line = (m_line + 1) % N_LINES;
        f_rep = 3'(1 << src); f_tog = 1; outcome = "rotate";
      end else begin
        n_fail = 1; outcome = "linkdown";
      end
    end

    cmd_sent = 1'b1; cmd_src = 2'(src); reply_delay = 16'(d);
    tick();
    cmd_sent = 1'b0;

    if (d == 0) begin
      m_retry = 0; m_tried = 0;
      checks++;
      if (busy !== 1'b0 || repeat_req !== 3'b000 || cmd_drop !== 1'b0) begin
        errors++;
        $display("FAIL zero_delay: busy/rep/drop=%b/%b/%b required 0/000/0", busy, repeat_req, cmd_drop);
      end
    end else begin
      last_k = succ ? e + 1 : r + 1;
      for (int k = 1; k <= last_k; k++) begin
        if (!succ && k == r) begin
          m_retry = n_retry; m_tried = n_tried; m_line = n_line; m_fail = n_fail;
        end
        exp_rep  = (!succ && k == r) ? f_rep : 3'b000;
        exp_tog  = (!succ && k == r) ? f_tog : 1'b0;
        exp_busy = succ ? (k <= e) : (k <= r);
        exp_drop = extra && (k == 2);

        checks++;
        if (repeat_req !== exp_rep) begin
          errors++;
          $display("FAIL repeat_req txn %0d cycle %0d: got %b required %b", txn_no, k, repeat_req, exp_rep);
        end
        checks++;
        if (busy !== exp_busy) begin
          errors++;
          $display("FAIL busy txn %0d cycle %0d: got %b required %b", txn_no, k, busy, exp_busy);
        end
        checks++;
        if (line_toggle !== exp_tog || line_sel !== 1'(m_line)) begin
          errors++;
          $display("FAIL line txn %0d cycle %0d: toggle/sel got %b/%0d required %b/%0d",
                   txn_no, k, line_toggle, line_sel, exp_tog, m_line);
        end
        checks++;
        if (link_fail !== m_fail || cmd_drop !== exp_drop) begin
          errors++;
          $display("FAIL link_fail/cmd_drop txn %0d cycle %0d: got %b/%b required %b/%b",
                   txn_no, k, link_fail, cmd_drop, m_fail, exp_drop);
        end

        rx_start_bit = (start_at > 0) && (k == start_at);
        rx_frame_end = ((early_end > 0) && (k == early_end)) || ((e > 0) && (k == e));
        rx_err       = err;
        cmd_sent     = extra && (k == 1);
        cmd_src      = 2'($urandom_range(0, 2));
        tick();
        rx_start_bit = 1'b0; rx_frame_end = 1'b0; rx_err = 1'b0; cmd_sent = 1'b0;
      end
      if (succ) begin
        m_retry = 0; m_tried = 0;
      end
    end
    $display("txn %0d src=%0d d=%0d start=%0d end_after=%0d err=%0d early=%0d extra=%0d -> %s line=%0d",
             txn_no, src, d, start_at, end_after, err, early_end, extra, outcome, m_line);
    txn_no++;
  endtask

  task automatic do_fail_clr();
    cmd_sent = 1'b1; cmd_src = 2'd0; reply_delay = 16'd5;
    tick();
    cmd_sent = 1'b0;
    checks++;
    if (cmd_drop !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_in_fail: drop/busy got %b/%b required 1/0", cmd_drop, busy);
    end
    fail_clr = 1'b1;
    tick();
    fail_clr = 1'b0;
    m_fail = 0; m_retry = 0; m_tried = 0;
    checks++;
    if (link_fail !== 1'b0 || line_sel !== 1'(m_line) || cmd_drop !== 1'b0) begin
      errors++;
      $display("FAIL fail_clr: link_fail/line_sel/drop got %b/%0d/%b required 0/%0d/0",
               link_fail, line_sel, cmd_drop, m_line);
    end
    $display("txn %0d fail_clr line=%0d", txn_no, m_line);
    txn_no++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_sent = 0; cmd_src = 0; reply_delay = 0;
    rx_start_bit = 0; rx_frame_end = 0; rx_err = 0; fail_clr = 0;
    repeat (3) tick();
    checks++;
    if ({repeat_req, line_sel, line_toggle, link_fail, busy, cmd_drop} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {repeat_req, line_sel, line_toggle, link_fail, busy, cmd_drop});
    end
    rst = 1'b0;
    tick();
    m_retry = 0; m_tried = 0; m_line = 0; m_fail = 0;
  endtask

  task automatic test_timeout_latency();
    run_txn(1, 10, 0, 0, 0, 0, 0);
  endtask

  task automatic test_start_at_expiry();
    run_txn(0, 10, 10, 20, 0, 0, 0);
    // Counters were cleared, so the next two timeouts are plain repeats.
    run_txn(0, 3, 0, 0, 0, 0, 0);
    run_txn(0, 3, 0, 0, 0, 0, 0);
    run_txn(0, 2, 0, 0, 1, 2, 0);
    run_txn(1, 4, 2, 3, 0, 0, 1);
  endtask

  task automatic test_rotation_and_fail();
    for (int i = 0; i < 3; i++) run_txn(2, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_txn(2, 4, 0, 0, 0, 0, 0);
    if (m_fail) do_fail_clr();
  endtask

  task automatic test_frame_timeout();
    run_txn(0, 6, 3, 0, 0, 0, 0);
    run_txn(1, 6, 2, 5, 1, 0, 0);
    run_txn(1, 6, 2, 5, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cmd_sent = 1'b1; cmd_src = 2'd1; reply_delay = 16'd8;
    tick();
    cmd_sent = 1'b0; rx_start_bit = 1'b1;
    tick();
    rx_start_bit = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({repeat_req, line_sel, line_toggle, link_fail, busy, cmd_drop} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_wait_end: got %b required 00000000",
               {repeat_req, line_sel, line_toggle, link_fail, busy, cmd_drop});
    end
    m_retry = 0; m_tried = 0; m_line = 0; m_fail = 0;
    // Reset coinciding with the timeout cycle must discard the pending repeat.
    cmd_sent = 1'b1; cmd_src = 2'd2; reply_delay = 16'd2;
    tick();
    cmd_sent = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (repeat_req !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard_repeat: rep/busy got %b/%b required 000/0", repeat_req, busy);
    end
    $display("txn %0d reset_mid checked", txn_no);
    txn_no++;
    tick();
  endtask

  task automatic test_bad_src();
    cmd_sent = 1'b1; cmd_src = 2'd3; reply_delay = 16'd5;
    tick();
    cmd_sent = 1'b0; rx_start_bit = 1'b1; rx_frame_end = 1'b1;
    checks++;
    if (cmd_drop !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_src: drop/busy got %b/%b required 1/0", cmd_drop, busy);
    end
    tick();
    rx_start_bit = 1'b0; rx_frame_end = 1'b0;
    tick();
    checks++;
    if (cmd_drop !== 1'b0 || busy !== 1'b0 || repeat_req !== 3'b000) begin
      errors++;
      $display("FAIL idle_ignores_rx: drop/busy/rep got %b/%b/%b required 0/0/000",
               cmd_drop, busy, repeat_req);
    end
    $display("txn %0d bad_src checked", txn_no);
    txn_no++;
  endtask

  task automatic test_random();
    int kind, src, d, s, ea;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      src  = $urandom_range(0, N_SRC - 1);
      d    = $urandom_range(1, 12);
      case (kind)
        0: run_txn(src, d, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        1: begin
          s  = $urandom_range(1, d);
          ea = $urandom_range(1, 15);
          run_txn(src, d, s, ea, ($urandom_range(0, 9) < 3), 0, 1'($urandom_range(0, 1)));
        end
        2: run_txn(src, d, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(1, d), 0);
        default: run_txn(src, 0, 0, 0, 0, 0, 0);
      endcase
      if (m_fail) do_fail_clr();
    end
  endtask

  initial begin
    test_reset();
    test_timeout_latency();
    test_start_at_expiry();
    test_rotation_and_fail();
    test_frame_timeout();
    test_reset_mid();
    test_bad_src();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
